// File: rtl/fp_norm_pkg.sv
// Shared definitions for the floating-point normalisation pipeline.
//   EXP_W_DEF / MAN_W_DEF : default exponent field width and mantissa width
//                           (mantissa width includes the hidden bit)
//   fp_flags_t            : per-result status flags
//   exp_all_ones()        : all-ones biased exponent (Inf/overflow code) for
//                           a given exponent field width
package fp_norm_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 24;

  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
    logic inexact;
  } fp_flags_t;

  // Largest normal biased exponent is exp_all_ones(w) - 1; anything at or
  // above exp_all_ones(w) overflows.
  function automatic int exp_all_ones(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter.
//   in_bits  : W-bit vector, MSB first
//   count    : number of zeros above the most significant set bit
//              (equals W when the vector is zero)
//   all_zero : 1 when in_bits is zero
module fp_lzc #(
  parameter int W  = 47,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_bits,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  // Scan from LSB upward so the highest set bit is the last one to write.
  always_comb begin
    count    = CW'(W);
    all_zero = (in_bits == '0);
    for (int i = 0; i < W; i++) begin
      if (in_bits[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage normaliser for raw multiply/divide mantissas.
//   Stage 1 registers the input with its leading-zero count and zero flag.
//   Stage 2 normalises, adjusts the exponent, handles overflow, gradual
//   underflow or flush-to-zero, and registers the result with its flags.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake
//   in_mant               : raw mantissa, bit IN_W-1 weight 2, bit IN_W-2 weight 1
//   in_exp                : signed two's-complement biased exponent
//   in_ftz                : 1 = flush subnormal results to zero
//   out_valid/out_ready   : output handshake
//   out_mant              : {hidden, fraction, G, R, S}
//   out_exp               : biased result exponent
//   out_zero/out_underflow/out_overflow/out_inexact : result flags
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; a producer holds valid and data steady until that edge. The whole
// pipe moves together on adv = !out_valid | out_ready, and in_ready = adv, so
// a stalled output freezes every stage and holds the outputs steady.
module fp_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int IN_W  = 2 * MAN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_mant,
  input  logic [EXP_W+1:0]   in_exp,
  input  logic               in_ftz,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAN_W+2:0]   out_mant,
  output logic [EXP_W-1:0]   out_exp,
  output logic               out_zero,
  output logic               out_underflow,
  output logic               out_overflow,
  output logic               out_inexact
);

  localparam int LZ_W = $clog2(IN_W);
  // Wide enough for in_exp + 1 and in_exp - (IN_W-2) without wrapping.
  localparam int E_W  = EXP_W + 3 + LZ_W;
  localparam int M_W  = MAN_W + 3;
  localparam int SH_W = $clog2(M_W);

  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_OVF  = E_W'(exp_all_ones(EXP_W));
  localparam logic signed [E_W-1:0] SH_MAX = E_W'(MAN_W + 2);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: leading-zero count, zero detect
  logic [LZ_W-1:0] lz_cnt;
  logic            lz_zero;

  fp_lzc #(.W(IN_W - 1), .CW(LZ_W)) u_lzc (
    .in_bits  (in_mant[IN_W-2:0]),
    .count    (lz_cnt),
    .all_zero (lz_zero)
  );

  logic             s1_valid;
  logic [IN_W-1:0]  s1_mant;
  logic [EXP_W+1:0] s1_exp;
  logic             s1_ftz;
  logic [LZ_W-1:0]  s1_lzc;
  logic             s1_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_ftz   <= 1'b0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mant  <= in_mant;
      s1_exp   <= in_exp;
      s1_ftz   <= in_ftz;
      s1_lzc   <= lz_cnt;
      s1_zero  <= lz_zero && !in_mant[IN_W-1];
    end
  end

  // ---------------- stage 2: shift, exponent adjust
  logic signed [E_W-1:0] exp_ext, lz_ext, e, sh;
  logic [IN_W-1:0]       norm;
  logic [M_W-1:0]        mant_n, mant_sub;
  logic [SH_W-1:0]       sh_amt;

  always_comb begin
    exp_ext = {{(E_W-EXP_W-2){s1_exp[EXP_W+1]}}, s1_exp};
    lz_ext  = {{(E_W-LZ_W){1'b0}}, s1_lzc};
    // norm carries the hidden bit at IN_W-1; the right-shift case simply
    // reinterprets the input, so its old LSB lands in the sticky range.
    if (s1_mant[IN_W-1]) begin
      e    = exp_ext + E_ONE;
      norm = s1_mant;
    end else begin
      e    = exp_ext - lz_ext;
      norm = (s1_mant << s1_lzc) << 1;
    end
    mant_n = {norm[IN_W-1 -: MAN_W+2], |norm[IN_W-MAN_W-3:0]};

    // Denormalising shift by 1-e; only meaningful when e <= 0, where sh >= 1.
    sh       = E_ONE - e;
    sh_amt   = sh[SH_W-1:0];
    mant_sub = mant_n >> sh_amt;
    mant_sub[0] = mant_sub[0] | (|(mant_n & ~({M_W{1'b1}} << sh_amt)));
    if (sh > SH_MAX) mant_sub = {{(M_W-1){1'b0}}, 1'b1};
  end

  // ---------------- stage 2: result classification
  logic [M_W-1:0]   res_mant;
  logic [EXP_W-1:0] res_exp;
  fp_flags_t        res_flags;

  always_comb begin
    res_mant  = '0;
    res_exp   = '0;
    res_flags = '0;
    if (s1_zero) begin
      res_flags.zero = 1'b1;
    end else if (e >= E_OVF) begin
      res_exp            = '1;
      res_flags.overflow = 1'b1;
    end else if (e < E_ONE) begin
      res_flags.underflow = 1'b1;
      if (s1_ftz) begin
        // Nonzero input flushed away, so precision was necessarily lost.
        res_flags.zero    = 1'b1;
        res_flags.inexact = 1'b1;
      end else begin
        res_mant          = mant_sub;
        res_flags.inexact = |mant_sub[2:0];
      end
    end else begin
      res_mant          = mant_n;
      res_exp           = e[EXP_W-1:0];
      res_flags.inexact = |mant_n[2:0];
    end
  end

  fp_flags_t flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      flags_q   <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_mant  <= res_mant;
      out_exp   <= res_exp;
      flags_q   <= res_flags;
    end
  end

  assign out_zero      = flags_q.zero;
  assign out_underflow = flags_q.underflow;
  assign out_overflow  = flags_q.overflow;
  assign out_inexact   = flags_q.inexact;

endmodule
